collision_scheduler: RTL and testbench
======================================

// Module: collision_scheduler
// PURPOSE
//  Once per frame, time-multiplexes one shared registered rectangle-overlap comparator.
//  Checks the ball rectangle against N_TARGETS rectangles (paddles, walls, net).
//  Snapshots all rectangles on frame_start_i, issues one pair per cycle to the comparator,
//  collects the hits and publishes them together with a one-cycle done_o pulse.
//  Sits between the sprite position logic and the game-state FSM (bounce/score).
// PARAMETERS
//  N_TARGETS  4   number of target rectangles scanned against the ball (>=1)
//  X_POS_W    10  width of x_pos/right fields
//  Y_POS_W    10  width of y_pos/bottom fields
//  (local) RECT_W = 2*X_POS_W+2*Y_POS_W; packing {x_pos,y_pos,right,bottom}, x_pos in MSBs
// PORTS
//  clk_i          in   1               system clock
//  rst_i          in   1               synchronous reset, active-high
//  frame_start_i  in   1               one-cycle pulse: start a scan (e.g. end of active video)
//  en_mask_i      in   N_TARGETS       per-target enable; disabled targets report 0
//  ball_i         in   RECT_W          ball rectangle, x_pos=left, y_pos=top
//  tgt_i          in   N_TARGETS*RECT_W  target i at [i*RECT_W +: RECT_W]
//  cmp_valid_o    out  1               pair on cmp_rect_*_o is being issued this cycle
//  cmp_rect_1_o   out  RECT_W          comparator operand 1 (snapshot ball)
//  cmp_rect_2_o   out  RECT_W          comparator operand 2 (snapshot target idx)
//  cmp_hit_i      in   1               comparator result, registered, valid 1 cycle after issue
//  busy_o         out  1               scan in progress (state != IDLE)
//  done_o         out  1               one-cycle pulse: hits_o/any_hit_o/first_hit_o just updated
//  hits_o         out  N_TARGETS       per-target collision flags of last completed scan
//  any_hit_o      out  1               |hits_o
//  first_hit_o    out  $clog2(N_TARGETS) max 1  lowest index set in hits_o (0 if none)
//  overrun_o      out  1               sticky: frame_start_i arrived while busy
// BEHAVIOUR
//  Reset: state IDLE; busy_o, done_o, cmp_valid_o, hits_o, any_hit_o, first_hit_o, overrun_o = 0.
//  Reset also clears the index, accumulator and snapshot regs.
//  cmp_rect_*_o are don't-care when cmp_valid_o=0.
//  FSM: IDLE -> RUN -> DRAIN -> DONE -> IDLE.
//  IDLE: frame_start_i=1 at cycle t0 -> latch ball_i, tgt_i and en_mask_i into snapshot regs.
//    In the same transition: idx=0, clear accumulator, go RUN.
//  RUN (t1..tN): cmp_valid_o=1; operands driven from snapshot and idx.
//    idx increments each cycle; after idx=N_TARGETS-1 go DRAIN.
//  Sampling: a 1-cycle delayed copy of (cmp_valid_o, idx) qualifies cmp_hit_i.
//    acc[idx_d] <= cmp_hit_i & mask_snap[idx_d]. Samples occur in t2..t(N+1).
//  DRAIN (t(N+1)): samples the last result, cmp_valid_o=0, go DONE.
//  DONE (t(N+2)): hits_o<=acc; any_hit_o, first_hit_o updated in the same cycle; done_o=1; go IDLE.
//  Fixed latency: done_o exactly N_TARGETS+2 cycles after the accepted frame_start_i.
//    Latency is independent of en_mask_i; disabled targets are still scanned.
//  Outputs are held between scans; they are never partially updated mid-scan.
//  frame_start_i while busy_o=1 (including in DONE): ignored, overrun_o<=1 (sticky until reset).
//  Input changes after t0 do not affect the running scan (snapshot).
//  rst_i mid-scan: abort to IDLE; no done_o; all outputs as at reset.
//  N_TARGETS=1: RUN lasts one cycle; first_hit_o width is 1.
//  Index counter width is $clog2(N_TARGETS) max 1; it must never wrap past N_TARGETS-1.
// TESTING (bench uses reference comparator model: strict-overlap, 1-cycle registered)
//  1. Setup: N=4; ball {100,100,108,108}; tgt0 {104,90,112,130}; others far away; mask=4'hF.
//     frame_start at t0 -> cmp_valid_o high t1..t4, done_o at t6.
//     Expected: hits_o=4'b0001, any_hit_o=1, first_hit_o=0.
//  2. Same as 1, plus tgt2 overlapping ball, mask=4'b1011.
//     Expected: hits_o=4'b0001. Then mask=4'hF -> hits_o=4'b0101, first_hit_o=0.
//  3. Edge touch: tgt1 right=100 = ball x_pos, otherwise overlapping.
//     Expected: hits_o[1]=0, any_hit_o=0 if tgt1 is the only candidate.
//  4. Second frame_start_i at t3 and another at t6.
//     Expected: both ignored, overrun_o=1, done_o once at t6, busy_o low at t7.
//  5. Modify ball_i at t2 of a scan.
//     Expected: results match the t0 snapshot; the next scan uses the new value.
//  6. rst_i at t3.
//     Expected: busy_o=0 at t4, no done_o, hits_o=0; a new frame_start_i then completes normally.

Source files
------------

// File: rtl/collision_scheduler.sv
// rtl/collision_scheduler.sv - once-per-frame ball/target overlap scan over one shared registered comparator
module collision_scheduler #(
  parameter int N_TARGETS = 4,
  parameter int X_POS_W   = 10,
  parameter int Y_POS_W   = 10,
  localparam int RECT_W   = 2 * X_POS_W + 2 * Y_POS_W,
  localparam int IDX_W    = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          frame_start_i,
  input  logic [N_TARGETS-1:0]          en_mask_i,
  input  logic [RECT_W-1:0]             ball_i,
  input  logic [N_TARGETS*RECT_W-1:0]   tgt_i,
  output logic                          cmp_valid_o,
  output logic [RECT_W-1:0]             cmp_rect_1_o,
  output logic [RECT_W-1:0]             cmp_rect_2_o,
  input  logic                          cmp_hit_i,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [N_TARGETS-1:0]          hits_o,
  output logic                          any_hit_o,
  output logic [IDX_W-1:0]              first_hit_o,
  output logic                          overrun_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TARGETS - 1);

  state_t                 state;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_d;
  logic                   valid_d;
  logic [N_TARGETS-1:0]   acc;
  logic [N_TARGETS-1:0]   acc_nxt;
  logic [N_TARGETS-1:0]   mask_snap;
  logic [RECT_W-1:0]      ball_snap;
  logic [RECT_W-1:0]      tgt_snap [N_TARGETS];

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N_TARGETS-1:0] v);
    lowest_set = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = IDX_W'(i);
    end
  endfunction

  assign cmp_rect_1_o = ball_snap;
  assign cmp_rect_2_o = tgt_snap[idx];

  // The comparator answers one cycle after issue, so the delayed index tags the result.
  always_comb begin
    acc_nxt = acc;
    if (valid_d) acc_nxt[idx_d] = cmp_hit_i & mask_snap[idx_d];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      idx         <= '0;
      idx_d       <= '0;
      valid_d     <= 1'b0;
      acc         <= '0;
      mask_snap   <= '0;
      ball_snap   <= '0;
      for (int i = 0; i < N_TARGETS; i++) tgt_snap[i] <= '0;
      cmp_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      hits_o      <= '0;
      any_hit_o   <= 1'b0;
      first_hit_o <= '0;
      overrun_o   <= 1'b0;
    end else begin
      valid_d <= cmp_valid_o;
      idx_d   <= idx;
      acc     <= acc_nxt;
      if (frame_start_i && state != IDLE) overrun_o <= 1'b1;

      case (state)
        IDLE: begin
          done_o <= 1'b0;
          if (frame_start_i) begin
            ball_snap <= ball_i;
            mask_snap <= en_mask_i;
            for (int i = 0; i < N_TARGETS; i++) tgt_snap[i] <= tgt_i[i*RECT_W +: RECT_W];
            idx         <= '0;
            acc         <= '0;
            busy_o      <= 1'b1;
            cmp_valid_o <= 1'b1;
            state       <= RUN;
          end
        end
        RUN: begin
          if (idx == LAST_IDX) begin
            cmp_valid_o <= 1'b0;
            state       <= DRAIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DRAIN: begin
          // Publish including the result sampled this very cycle.
          hits_o      <= acc_nxt;
          any_hit_o   <= |acc_nxt;
          first_hit_o <= lowest_set(acc_nxt);
          done_o      <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// tb/tb_collision_scheduler.sv - randomized scan bench with a frame-level reference model
module tb_collision_scheduler;
  localparam int N  = 4;
  localparam int RW = 40;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            frame_start = 1'b0;
  logic [N-1:0]    en_mask = '0;
  logic [RW-1:0]   ball = '0;
  logic [N*RW-1:0] tgt = '0;
  logic            cmp_valid;
  logic [RW-1:0]   cmp_rect_1, cmp_rect_2;
  logic            cmp_hit = 1'b0;
  logic            busy, done, any_hit, overrun;
  logic [N-1:0]    hits;
  logic [1:0]      first_hit;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  collision_scheduler #(.N_TARGETS(N), .X_POS_W(10), .Y_POS_W(10)) dut (
    .clk_i(clk), .rst_i(rst), .frame_start_i(frame_start), .en_mask_i(en_mask),
    .ball_i(ball), .tgt_i(tgt), .cmp_valid_o(cmp_valid), .cmp_rect_1_o(cmp_rect_1),
    .cmp_rect_2_o(cmp_rect_2), .cmp_hit_i(cmp_hit), .busy_o(busy), .done_o(done),
    .hits_o(hits), .any_hit_o(any_hit), .first_hit_o(first_hit), .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] rect(input int x, input int y, input int r, input int b);
    return {10'(x), 10'(y), 10'(r), 10'(b)};
  endfunction

  function automatic bit overlap(input logic [RW-1:0] a, input logic [RW-1:0] t);
    return (a[39:30] < t[19:10]) && (t[39:30] < a[19:10]) &&
           (a[29:20] < t[9:0])   && (t[29:20] < a[9:0]);
  endfunction

  function automatic logic [N-1:0] predict(input logic [RW-1:0] b, input logic [N*RW-1:0] t,
                                           input logic [N-1:0] m);
    logic [N-1:0] h;
    for (int i = 0; i < N; i++) h[i] = m[i] & overlap(b, t[i*RW +: RW]);
    return h;
  endfunction

  function automatic logic [1:0] lowest(input logic [N-1:0] h);
    for (int i = 0; i < N; i++) if (h[i]) return 2'(i);
    return 2'd0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference comparator: strict overlap, one-cycle registered.
  always @(posedge clk) cmp_hit <= !rst && cmp_valid && overlap(cmp_rect_1, cmp_rect_2);

  // Frame-level model: phase = cycles since the accepted frame start (0 = idle).
  int              m_phase = 0;
  logic [RW-1:0]   m_ball = '0;
  logic [N*RW-1:0] m_tgt = '0;
  logic [N-1:0]    m_mask = '0;
  logic [N-1:0]    m_hits = '0;
  logic            m_any = 1'b0;
  logic [1:0]      m_first = '0;
  logic            m_over = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase <= 0; m_hits <= '0; m_any <= 1'b0; m_first <= '0; m_over <= 1'b0;
    end else begin
      if (frame_start && m_phase != 0) m_over <= 1'b1;
      if (m_phase == 0) begin
        if (frame_start) begin
          m_phase <= 1; m_ball <= ball; m_tgt <= tgt; m_mask <= en_mask;
        end
      end else begin
        m_phase <= (m_phase == N + 2) ? 0 : m_phase + 1;
      end
      if (m_phase == N + 1) begin
        m_hits  <= predict(m_ball, m_tgt, m_mask);
        m_any   <= |predict(m_ball, m_tgt, m_mask);
        m_first <= lowest(predict(m_ball, m_tgt, m_mask));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 64'(busy), 64'(m_phase != 0));
      check("cmp_valid", 64'(cmp_valid), 64'(m_phase >= 1 && m_phase <= N));
      check("done", 64'(done), 64'(m_phase == N + 2));
      check("hits", 64'(hits), 64'(m_hits));
      check("any_hit", 64'(any_hit), 64'(m_any));
      check("first_hit", 64'(first_hit), 64'(m_first));
      check("overrun", 64'(overrun), 64'(m_over));
      if (m_phase >= 1 && m_phase <= N) begin
        check("rect1", 64'(cmp_rect_1), 64'(m_ball));
        check("rect2", 64'(cmp_rect_2), 64'(m_tgt[(m_phase-1)*RW +: RW]));
      end
    end
  end

  logic [RW-1:0] new_ball;
  logic [11:0]   busy_tr, done_tr;

  task automatic scan_seq(input int e1, input int e2, input int mod_at, input int rst_at);
    @(negedge clk);
    frame_start = 1'b1;
    busy_tr = '0;
    done_tr = '0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      busy_tr[k] = busy;
      done_tr[k] = done;
      frame_start = (k == e1 || k == e2);
      rst = (k == rst_at);
      if (k == mod_at) ball = new_ball;
    end
    frame_start = 1'b0;
    rst = 1'b0;
  endtask

  function automatic logic [RW-1:0] far_rect();
    return rect(500, 500, 510, 510);
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hits", 64'(hits), 64'd0);

    // 1: target 0 overlaps the ball
    ball = rect(100, 100, 108, 108);
    tgt[0*RW +: RW] = rect(104, 90, 112, 130);
    tgt[1*RW +: RW] = far_rect();
    tgt[2*RW +: RW] = far_rect();
    tgt[3*RW +: RW] = far_rect();
    en_mask = 4'hF;
    scan_seq(0, 0, 0, 0);
    check("t1_done_at_t6", 64'(done_tr), 64'(12'b0000_0100_0000));
    check("t1_hits", 64'(hits), 64'(4'b0001));
    check("t1_any", 64'(any_hit), 64'd1);
    check("t1_first", 64'(first_hit), 64'd0);

    // 2: target 2 also overlaps, masked then unmasked
    tgt[2*RW +: RW] = rect(102, 102, 106, 106);
    en_mask = 4'b1011;
    scan_seq(0, 0, 0, 0);
    check("t2_masked_hits", 64'(hits), 64'(4'b0001));
    en_mask = 4'hF;
    scan_seq(0, 0, 0, 0);
    check("t2_hits", 64'(hits), 64'(4'b0101));
    check("t2_first", 64'(first_hit), 64'd0);

    // 3: target 1 only touches the ball's left edge
    tgt[0*RW +: RW] = far_rect();
    tgt[1*RW +: RW] = rect(90, 100, 100, 108);
    tgt[2*RW +: RW] = far_rect();
    scan_seq(0, 0, 0, 0);
    check("t3_hits", 64'(hits), 64'd0);
    check("t3_any", 64'(any_hit), 64'd0);

    // 4: frame starts at t3 and t6 are ignored
    tgt[0*RW +: RW] = rect(104, 90, 112, 130);
    check("t4_overrun_before", 64'(overrun), 64'd0);
    scan_seq(3, 6, 0, 0);
    check("t4_done_once", 64'(done_tr), 64'(12'b0000_0100_0000));
    check("t4_busy_t6", 64'(busy_tr[6]), 64'd1);
    check("t4_busy_t7", 64'(busy_tr[7]), 64'd0);
    check("t4_overrun", 64'(overrun), 64'd1);

    // 5: ball moves away at t2; the scan still uses the snapshot
    new_ball = rect(300, 300, 310, 310);
    scan_seq(0, 0, 2, 0);
    check("t5_snap_hits", 64'(hits), 64'(4'b0001));
    scan_seq(0, 0, 0, 0);
    check("t5_next_hits", 64'(hits), 64'd0);

    // 6: reset mid-scan, then a normal scan
    ball = rect(100, 100, 108, 108);
    scan_seq(0, 0, 0, 3);
    check("t6_busy_t4", 64'(busy_tr[4]), 64'd0);
    check("t6_no_done", 64'(done_tr), 64'd0);
    check("t6_hits", 64'(hits), 64'd0);
    check("t6_overrun", 64'(overrun), 64'd0);
    scan_seq(0, 0, 0, 0);
    check("t6_after_hits", 64'(hits), 64'(4'b0001));
    check("t6_after_done", 64'(done_tr), 64'(12'b0000_0100_0000));

    // Random traffic: inputs change every cycle, starts arrive at random.
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      frame_start = ($urandom_range(0, 4) == 0);
      rst = ($urandom_range(0, 199) == 0);
      en_mask = 4'($urandom);
      ball = rect($urandom_range(0, 40), $urandom_range(0, 40),
                  $urandom_range(0, 50), $urandom_range(0, 50));
      for (int i = 0; i < N; i++)
        tgt[i*RW +: RW] = rect($urandom_range(0, 40), $urandom_range(0, 40),
                               $urandom_range(0, 50), $urandom_range(0, 50));
    end
    frame_start = 1'b0;
    rst = 1'b0;
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
